sram_controller: RTL

Bridges the ACE processor core's 32-bit word memory requests to the DE1's 256K×16 asynchronous SRAM. Each 32-bit access is split into two 16-bit SRAM half-accesses: low half at even SRAM address, high half at odd. Sits between the processor core and the `sram_*` pins of the DE1 top-level wrapper, which connects its SRAM ports straight to the board.

---
 rtl/ace_mem_pkg.sv | 37 +++
 rtl/sram_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_mem_pkg.sv
// Shared memory-subsystem definitions: SRAM geometry, the word request
// field widths used by the processor core, and the SRAM controller FSM
// state and debug types.
package ace_mem_pkg;

    // Board SRAM geometry (256K x 16).
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // Processor-side word request/response fields.
    localparam int WORD_ADDR_W = 17;
    localparam int WORD_W      = 32;
    localparam int BE_W        = WORD_W / 8;

    // Controller phases: IDLE waits for a request, LO/HI drive one 16-bit
    // half each, DONE issues the completion pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    // Observable controller state for checkers: FSM state and whether the
    // controller is currently driving the SRAM data bus.
    typedef struct packed {
        sram_state_e state;
        logic        dq_oe;
    } sram_dbg_t;

    // True when the write byte enables for one 16-bit half are all clear,
    // meaning that half needs no SRAM cycle.
    function automatic logic half_unused(input logic [BE_W-1:0] be, input logic hi);
        return hi ? (be[3:2] == 2'b00) : (be[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Word-to-halfword bridge between the processor's 32-bit memory requests
// and the 256K x 16 asynchronous SRAM. Each word access becomes up to two
// 16-bit SRAM cycles (low half at the even address, high half at the odd
// address). All SRAM strobes, the address and the data-bus enable come
// straight from flops so the pins never glitch.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. req_ready is 1 only while idle; the request fields
// are captured on that edge and the requester may change them afterwards.
// Completion (read or write) is signalled by a single-cycle resp_valid;
// resp_rdata is valid with it and holds until the next read completes.
module sram_controller
    import ace_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int HALF_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [WORD_W-1:0]      req_wdata,
    input  logic [BE_W-1:0]        req_be,
    output logic                   resp_valid,
    output logic [WORD_W-1:0]      resp_rdata,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    inout  wire  [SRAM_DATA_W-1:0] sram_dq,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n,
    output sram_dbg_t              dbg
);

    localparam int CNT_W = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYCLES - 1);

    // A half-access needs at least one strobe cycle plus one hold cycle.
    if (HALF_CYCLES < 2) begin : g_bad_half_cycles
        $error("sram_controller: HALF_CYCLES must be at least 2");
    end

    sram_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_last;

    // Captured request.
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [BE_W-1:0]       be_q;

    // Request fields as seen by the next-state/output logic: live inputs
    // on the accepting edge, captured copies afterwards.
    logic                  cur_write;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [WORD_W-1:0]     cur_wdata;
    logic [BE_W-1:0]       cur_be;
    logic                  accept;

    // Registered SRAM pin values and their next values.
    logic [SRAM_ADDR_W-1:0] sram_addr_d;
    logic                   we_n_d, oe_n_d, ce_n_d, ub_n_d, lb_n_d;
    logic                   dq_oe_q, dq_oe_d;
    logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
    logic                   resp_valid_d;

    // Low half of a read, parked until the high half arrives.
    logic [SRAM_DATA_W-1:0] lo_buf_q;

    logic active_d;
    logic half_d;

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign phase_last = (cnt_q == CNT_LAST);

    assign cur_write = (state_q == ST_IDLE) ? req_write : write_q;
    assign cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign cur_be    = (state_q == ST_IDLE) ? req_be    : be_q;

    // Tri-state buffer: the bus is driven only during write phases.
    assign sram_dq = dq_oe_q ? dq_out_q : {SRAM_DATA_W{1'bz}};

    assign dbg = {state_q, dq_oe_q};

    // State register and half-phase cycle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sequence through the halves, skipping write halves with
    // no enabled bytes; the counter restarts whenever the phase changes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!cur_write) begin
                        state_d = ST_LO;
                    end else if (cur_be == '0) begin
                        state_d = ST_DONE;
                    end else if (half_unused(cur_be, 1'b0)) begin
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (phase_last) begin
                    if (write_q && half_unused(be_q, 1'b1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (phase_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == state_q) && ((state_q == ST_LO) || (state_q == ST_HI))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Output decode from the upcoming state so every pin can be registered
    // and still line up with the cycle it belongs to.
    always_comb begin
        active_d     = (state_d == ST_LO) || (state_d == ST_HI);
        half_d       = (state_d == ST_HI);
        sram_addr_d  = sram_addr;
        we_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        ce_n_d       = 1'b1;
        ub_n_d       = 1'b1;
        lb_n_d       = 1'b1;
        dq_oe_d      = 1'b0;
        dq_out_d     = dq_out_q;
        resp_valid_d = (state_d == ST_DONE);

        if (active_d) begin
            sram_addr_d = SRAM_ADDR_W'({cur_addr, half_d});
            ce_n_d      = 1'b0;
            if (cur_write) begin
                // Strobe low except in the final cycle of the phase, which
                // holds address and data stable after we_n rises.
                we_n_d   = (cnt_d == CNT_LAST);
                lb_n_d   = half_d ? ~cur_be[2] : ~cur_be[0];
                ub_n_d   = half_d ? ~cur_be[3] : ~cur_be[1];
                dq_oe_d  = 1'b1;
                dq_out_d = half_d ? cur_wdata[31:16] : cur_wdata[15:0];
            end else begin
                oe_n_d = 1'b0;
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
        end
    end

    // Capture the request fields on the accepting edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // SRAM pins and the bus enable; reset forces strobes inactive and
    // releases the bus immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sram_addr  <= '0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
            resp_valid <= 1'b0;
        end else begin
            sram_addr  <= sram_addr_d;
            sram_we_n  <= we_n_d;
            sram_oe_n  <= oe_n_d;
            sram_ce_n  <= ce_n_d;
            sram_ub_n  <= ub_n_d;
            sram_lb_n  <= lb_n_d;
            dq_oe_q    <= dq_oe_d;
            dq_out_q   <= dq_out_d;
            resp_valid <= resp_valid_d;
        end
    end

    // Read path: sample each half at the end of its last cycle; the word is
    // presented as the FSM enters DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lo_buf_q   <= '0;
            resp_rdata <= '0;
        end else begin
            if ((state_q == ST_LO) && phase_last && !write_q) begin
                lo_buf_q <= sram_dq;
            end
            if ((state_q == ST_HI) && phase_last && !write_q) begin
                resp_rdata <= {sram_dq, lo_buf_q};
            end
        end
    end

endmodule
